// File: rtl/lsu_aligned_if.sv
// lsu_aligned_if: wishbone data bus between the load/store unit and memory
interface wishbone #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] ADR;
  logic [XLEN-1:0] DAT_W;
  logic [XLEN-1:0] DAT_R;
  logic [XLEN/8-1:0] SEL;
  logic WE;
  logic STB;
  logic ACK;
  modport MASTER (output ADR, DAT_W, SEL, WE, STB, input DAT_R, ACK);
  modport SLAVE (input ADR, DAT_W, SEL, WE, STB, output DAT_R, ACK);
endinterface

// File: rtl/lsu_aligned.sv
// lsu_aligned: wishbone load/store unit with lane placement, alignment/legality checks and bus timeout
module lsu_aligned #(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ieu_we,
  input  logic            ieu_re,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ieu_reg,
  input  logic [XLEN-1:0] ieu_result,
  output logic            stalled,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_valid,
  output logic            misaligned,
  output logic            illegal,
  output logic            bus_timeout,
  wishbone.MASTER         mm_bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, nxt;
  logic [XLEN-1:0] adr, dat_w, sh, t, ext;
  logic signed [XLEN-1:0] ts;
  logic [NB-1:0] sel, bm;
  logic [OW-1:0] off, off_q, lm;
  logic [1:0] sz, sz_q;
  logic [CW-1:0] cnt;
  logic [6:0] sa;
  logic we_q, uns_q, req, bad, mis, go, expire;
  always_comb begin
    req = ieu_re | ieu_we;
    sz = funct3[1:0];
    off = ieu_result[OW-1:0];
    bad = funct3 == 3'b111 || (funct3[2] && ieu_we) ||
          (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110));
    lm = ~({OW{1'b1}} << sz);
    bm = ~({NB{1'b1}} << (4'd1 << sz));
    mis = (off & lm) != '0;
    go = req && !bad && !mis;
    expire = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    // left-justify the loaded field, then shift back down to sign- or zero-extend it
    sh = mm_bus.DAT_R >> {off_q, 3'b000};
    sa = 7'(XLEN) - (7'd8 << sz_q);
    t = sh << sa;
    ts = $signed(t) >>> sa;
    ext = uns_q ? t >> sa : ts;
    nxt = state == IDLE ? (go ? BUS : IDLE) :
          state == BUS ? (mm_bus.ACK || expire ? RESP : BUS) : IDLE;
    stalled = !rst && (state == BUS || (state == IDLE && go));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      adr <= '0;
      dat_w <= '0;
      sel <= '0;
      we_q <= 1'b0;
      sz_q <= '0;
      uns_q <= 1'b0;
      off_q <= '0;
      cnt <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      bus_timeout <= 1'b0;
      misaligned <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      rd_valid <= 1'b0;
      bus_timeout <= 1'b0;
      misaligned <= state == IDLE && req && !bad && mis;
      illegal <= state == IDLE && req && bad;
      cnt <= state == BUS ? cnt + 1'b1 : '0;
      if (state == IDLE && go) begin
        adr <= {ieu_result[XLEN-1:OW], {OW{1'b0}}};
        dat_w <= ieu_reg << {off, 3'b000};
        sel <= bm << off;
        we_q <= ieu_we;
        sz_q <= sz;
        uns_q <= funct3[2];
        off_q <= off;
      end
      if (state == BUS) begin
        if (mm_bus.ACK) begin
          if (!we_q) rd_data <= ext;
          rd_valid <= !we_q;
        end else if (expire) begin
          rd_data <= '0;
          bus_timeout <= 1'b1;
        end
      end
    end
  end
  assign mm_bus.ADR = adr;
  assign mm_bus.DAT_W = dat_w;
  assign mm_bus.SEL = sel;
  assign mm_bus.WE = we_q;
  assign mm_bus.STB = state == BUS;
endmodule

// File: tb/tb_lsu_aligned.sv
// tb_lsu_aligned: directed checks of lsu_aligned at XLEN=32 (TIMEOUT=4) and XLEN=64
module tb_lsu_aligned;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic we32 = 1'b0, re32 = 1'b0, we64 = 1'b0, re64 = 1'b0;
  logic [2:0] f32 = '0, f64 = '0;
  logic [31:0] reg32 = '0, res32 = '0, rd32;
  logic [63:0] reg64 = '0, res64 = '0, rd64;
  logic st32, rv32, mis32, ill32, to32;
  logic st64, rv64, mis64, ill64, to64;
  int n = 0;
  int nf = 0;
  wishbone #(.XLEN(32)) wb32 ();
  wishbone #(.XLEN(64)) wb64 ();
  lsu_aligned #(.XLEN(32), .TIMEOUT(4)) d32 (
    .clk(clk), .rst(rst), .ieu_we(we32), .ieu_re(re32), .funct3(f32),
    .ieu_reg(reg32), .ieu_result(res32), .stalled(st32), .rd_data(rd32),
    .rd_valid(rv32), .misaligned(mis32), .illegal(ill32), .bus_timeout(to32),
    .mm_bus(wb32)
  );
  lsu_aligned #(.XLEN(64)) d64 (
    .clk(clk), .rst(rst), .ieu_we(we64), .ieu_re(re64), .funct3(f64),
    .ieu_reg(reg64), .ieu_result(res64), .stalled(st64), .rd_data(rd64),
    .rd_valid(rv64), .misaligned(mis64), .illegal(ill64), .bus_timeout(to64),
    .mm_bus(wb64)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req32(input logic w, input logic r, input logic [2:0] f,
                       input logic [31:0] d, input logic [31:0] a);
    we32 = w; re32 = r; f32 = f; reg32 = d; res32 = a;
  endtask
  task automatic req64(input logic w, input logic r, input logic [2:0] f,
                       input logic [63:0] d, input logic [63:0] a);
    we64 = w; re64 = r; f64 = f; reg64 = d; res64 = a;
  endtask
  initial begin
    wb32.ACK = 1'b0; wb32.DAT_R = '0;
    wb64.ACK = 1'b0; wb64.DAT_R = '0;
    req32(0, 1, 3'b010, 0, 32'h1004);
    tick; tick; #1;
    chk("rst_stalled", st32, 0);
    chk("rst_stb", wb32.STB, 0);
    chk("rst_sel", wb32.SEL, 0);
    chk("rst_adr", wb32.ADR, 0);
    chk("rst_rd", rd32, 0);
    chk("rst_rv", rv32, 0);
    rst = 1'b0;
    #1 chk("lw_stall0", st32, 1);
    tick;
    chk("lw_stb", wb32.STB, 1);
    chk("lw_adr", wb32.ADR, 32'h1004);
    chk("lw_sel", wb32.SEL, 4'hF);
    chk("lw_we", wb32.WE, 0);
    chk("lw_stall1", st32, 1);
    wb32.ACK = 1'b1; wb32.DAT_R = 32'h8000_00FF;
    tick;
    wb32.ACK = 1'b0;
    chk("lw_resp_stb", wb32.STB, 0);
    chk("lw_resp_stall", st32, 0);
    chk("lw_rv", rv32, 1);
    chk("lw_rd", rd32, 32'h8000_00FF);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    chk("lw_rv_once", rv32, 0);
    chk("lw_no_reissue", wb32.STB, 0);
    chk("lw_rd_hold", rd32, 32'h8000_00FF);
    req32(0, 1, 3'b000, 0, 32'h2003);
    tick;
    chk("lb_sel", wb32.SEL, 4'b1000);
    chk("lb_adr", wb32.ADR, 32'h2000);
    wb32.ACK = 1'b1; wb32.DAT_R = 32'h80AA_BBCC;
    tick;
    wb32.ACK = 1'b0;
    chk("lb_rd", rd32, 32'hFFFF_FF80);
    chk("lb_rv", rv32, 1);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    req32(0, 1, 3'b100, 0, 32'h2003);
    tick;
    wb32.ACK = 1'b1;
    tick;
    wb32.ACK = 1'b0;
    chk("lbu_rd", rd32, 32'h0000_0080);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    req32(1, 0, 3'b001, 32'h1234_5678, 32'h3002);
    tick;
    chk("sh_adr", wb32.ADR, 32'h3000);
    chk("sh_sel", wb32.SEL, 4'b1100);
    chk("sh_datw", wb32.DAT_W[31:16], 16'h5678);
    chk("sh_we", wb32.WE, 1);
    wb32.ACK = 1'b1;
    tick;
    wb32.ACK = 1'b0;
    chk("sh_rv", rv32, 0);
    chk("sh_rd_hold", rd32, 32'h0000_0080);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    wb32.ACK = 1'b1;
    tick;
    wb32.ACK = 1'b0;
    chk("idle_ack_stb", wb32.STB, 0);
    chk("idle_ack_rv", rv32, 0);
    req32(0, 1, 3'b010, 0, 32'h1002);
    #1 chk("mis_stall", st32, 0);
    tick;
    chk("mis_pulse", mis32, 1);
    chk("mis_ill", ill32, 0);
    chk("mis_stb", wb32.STB, 0);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    chk("mis_drop", mis32, 0);
    req32(0, 1, 3'b011, 0, 32'h1002);
    #1 chk("ill_stall", st32, 0);
    tick;
    chk("ill_pulse", ill32, 1);
    chk("ill_nomis", mis32, 0);
    chk("ill_stb", wb32.STB, 0);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    chk("ill_drop", ill32, 0);
    req32(1, 0, 3'b100, 0, 32'h1000);
    tick;
    chk("sbu_ill", ill32, 1);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    req32(1, 1, 3'b010, 32'hAABB_CCDD, 32'h6000);
    tick;
    chk("both_we", wb32.WE, 1);
    chk("both_datw", wb32.DAT_W, 32'hAABB_CCDD);
    wb32.ACK = 1'b1;
    tick;
    wb32.ACK = 1'b0;
    chk("both_rv", rv32, 0);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    req32(0, 1, 3'b010, 0, 32'h4000);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("to_stb_hi", wb32.STB, 1);
    end
    tick;
    chk("to_stb_lo", wb32.STB, 0);
    chk("to_pulse", to32, 1);
    chk("to_rv", rv32, 0);
    chk("to_rd", rd32, 0);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    chk("to_drop", to32, 0);
    req32(0, 1, 3'b010, 0, 32'h4004);
    for (int i = 0; i < 4; i++) tick;
    wb32.ACK = 1'b1; wb32.DAT_R = 32'h1357_9BDF;
    tick;
    wb32.ACK = 1'b0;
    chk("edge_rv", rv32, 1);
    chk("edge_to", to32, 0);
    chk("edge_rd", rd32, 32'h1357_9BDF);
    req32(0, 0, 3'b000, 0, 0);
    tick;
    req32(0, 1, 3'b010, 0, 32'h5000);
    tick;
    chk("rb_stb", wb32.STB, 1);
    rst = 1'b1;
    tick;
    chk("rb_stb_lo", wb32.STB, 0);
    chk("rb_adr", wb32.ADR, 0);
    chk("rb_sel", wb32.SEL, 0);
    chk("rb_rd", rd32, 0);
    chk("rb_stall", st32, 0);
    rst = 1'b0;
    req32(0, 0, 3'b000, 0, 0);
    tick;
    chk("rb_rv", rv32, 0);
    chk("rb_to", to32, 0);
    wb64.DAT_R = 64'hFEDC_BA98_7654_3210;
    req64(0, 1, 3'b011, 0, 64'h8);
    #1 chk("ld_stall", st64, 1);
    tick;
    chk("ld_sel", wb64.SEL, 8'hFF);
    chk("ld_adr", wb64.ADR, 64'h8);
    wb64.ACK = 1'b1;
    tick;
    wb64.ACK = 1'b0;
    chk("ld_rd", rd64, 64'hFEDC_BA98_7654_3210);
    chk("ld_rv", rv64, 1);
    req64(0, 0, 3'b000, 0, 0);
    tick;
    req64(0, 1, 3'b110, 0, 64'hC);
    tick;
    chk("lwu_sel", wb64.SEL, 8'hF0);
    chk("lwu_adr", wb64.ADR, 64'h8);
    wb64.ACK = 1'b1;
    tick;
    wb64.ACK = 1'b0;
    chk("lwu_rd", rd64, 64'h0000_0000_FEDC_BA98);
    req64(0, 0, 3'b000, 0, 0);
    tick;
    req64(0, 1, 3'b010, 0, 64'hC);
    tick;
    wb64.ACK = 1'b1;
    tick;
    wb64.ACK = 1'b0;
    chk("lw64_rd", rd64, 64'hFFFF_FFFF_FEDC_BA98);
    chk("lw64_ill", ill64, 0);
    req64(0, 0, 3'b000, 0, 0);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule
